// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with one shared 64-bit mtime counter
// (with prescaler) and per-hart mtimecmp / msip registers. Timer and software
// interrupt outputs are registered.
// Optional build macro: CLINT_SNAPSHOT_EN -- reading mtime low latches mtime
// high into a shadow register, and subsequent mtime high reads return it.
module clint_timer #(
    parameter int unsigned NHART     = 2,
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr_i,
    input  logic             read_valid_i,
    input  logic             write_valid_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic [NHART-1:0] timer_irq_o,
    output logic [NHART-1:0] soft_irq_o
);

    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      cmp_q [NHART];
    logic [63:0]      cmp_d [NHART];
    logic [NHART-1:0] msip_q, msip_d;
    logic [NHART-1:0] timer_irq_q, timer_irq_d;
    logic [NHART-1:0] soft_irq_q;
    logic             tick;

    logic [31:0] offset;
    logic        aligned;
    logic        msip_sel;
    logic        cmp_sel;
    logic        mtlo_sel;
    logic        mthi_sel;
    logic [3:0]  msip_idx;
    logic [3:0]  cmp_idx;
    logic        cmp_hi;

    // Address decode relative to the register window base
    assign offset   = addr_i - BASE_ADDR;
    assign aligned  = (offset[1:0] == 2'b00);
    assign msip_sel = aligned && (offset[31:2] < 30'(NHART));
    assign cmp_sel  = aligned && (offset[31:14] == 18'd1) && (offset[13:3] < 11'(NHART));
    assign mtlo_sel = (offset == 32'h0000_BFF8);
    assign mthi_sel = (offset == 32'h0000_BFFC);
    assign msip_idx = offset[5:2];
    assign cmp_idx  = offset[6:3];
    assign cmp_hi   = offset[2];

    assign tick = (presc_q == PMAX);

    // Prescaler and mtime next state; a write to either mtime half wins over
    // the tick and restarts the prescaler
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (write_valid_i && mtlo_sel) begin
            mtime_d = {mtime_q[63:32], wdata_i};
            presc_d = '0;
        end
        if (write_valid_i && mthi_sel) begin
            mtime_d = {wdata_i, mtime_q[31:0]};
            presc_d = '0;
        end
    end

    // Per-hart register next state and interrupt compare on the current mtime
    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            cmp_d[h]       = cmp_q[h];
            msip_d[h]      = msip_q[h];
            timer_irq_d[h] = (mtime_q >= cmp_q[h]);
            if (write_valid_i && msip_sel && (msip_idx == 4'(h))) begin
                msip_d[h] = wdata_i[0];
            end
            if (write_valid_i && cmp_sel && (cmp_idx == 4'(h))) begin
                if (cmp_hi) begin
                    cmp_d[h] = {wdata_i, cmp_q[h][31:0]};
                end else begin
                    cmp_d[h] = {cmp_q[h][63:32], wdata_i};
                end
            end
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    // Per-hart registers and registered interrupt outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int h = 0; h < NHART; h++) begin
                cmp_q[h] <= '1;
            end
            msip_q      <= '0;
            timer_irq_q <= '0;
            soft_irq_q  <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                cmp_q[h] <= cmp_d[h];
            end
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
            soft_irq_q  <= msip_q;
        end
    end

    assign timer_irq_o = timer_irq_q;
    assign soft_irq_o  = soft_irq_q;

`ifdef CLINT_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    // Shadow of mtime high, captured by a low-half read or a high-half write
    always_comb begin
        shadow_d = shadow_q;
        if (read_valid_i && mtlo_sel) begin
            shadow_d = mtime_q[63:32];
        end
        if (write_valid_i && mthi_sel) begin
            shadow_d = wdata_i;
        end
    end

    // Shadow register
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_read_valid;
    assign unused_read_valid = read_valid_i;
`endif

    // Combinational read mux; unmapped offsets return zero
    always_comb begin
        rdata_o = '0;
        if (mtlo_sel) begin
            rdata_o = mtime_q[31:0];
        end
        if (mthi_sel) begin
`ifdef CLINT_SNAPSHOT_EN
            rdata_o = shadow_q;
`else
            rdata_o = mtime_q[63:32];
`endif
        end
        for (int h = 0; h < NHART; h++) begin
            if (msip_sel && (msip_idx == 4'(h))) begin
                rdata_o = {31'd0, msip_q[h]};
            end
            if (cmp_sel && (cmp_idx == 4'(h))) begin
                rdata_o = cmp_hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
            end
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer (NHART=2, PRESCALE=4): directed scenarios followed by
// random register traffic, compared against an arithmetic model of mtime.
module tb_clint_timer;

    localparam int          NH   = 2;
    localparam int          P    = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_MTLO = BASE + 32'h0000_BFF8;
    localparam logic [31:0] A_MTHI = BASE + 32'h0000_BFFC;

    logic          clk;
    logic          rst;
    logic [31:0]   addr_i;
    logic          read_valid_i;
    logic          write_valid_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic [NH-1:0] timer_irq_o;
    logic [NH-1:0] soft_irq_o;

    clint_timer #(.NHART(NH), .PRESCALE(P), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .read_valid_i (read_valid_i),
        .write_valid_i(write_valid_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .timer_irq_o  (timer_irq_o),
        .soft_irq_o   (soft_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: mtime = value at last anchor + whole prescaler periods since
    logic [63:0]   m_base;
    int            m_n;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [31:0]   m_shadow;
    logic [NH-1:0] e_tirq;
    logic [NH-1:0] e_sirq;

    function automatic logic [31:0] a_msip(input int h);
        return BASE + 32'(4 * h);
    endfunction

    function automatic logic [31:0] a_cmp(input int h, input bit hi);
        return BASE + 32'h4000 + 32'(8 * h) + (hi ? 32'd4 : 32'd0);
    endfunction

    function automatic logic [63:0] m_mt();
        return m_base + 64'(m_n / P);
    endfunction

    task automatic m_reset();
        m_base   = 64'd0;
        m_n      = 0;
        m_msip   = '0;
        m_shadow = 32'd0;
        e_tirq   = '0;
        e_sirq   = '0;
        for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        logic [63:0] mt;
        off = a - BASE;
        mt  = m_mt();
        if (off == 32'hBFF8) return mt[31:0];
`ifdef CLINT_SNAPSHOT_EN
        if (off == 32'hBFFC) return m_shadow;
`else
        if (off == 32'hBFFC) return mt[63:32];
`endif
        for (int h = 0; h < NH; h++) begin
            if (off == 32'(4 * h)) return {31'd0, m_msip[h]};
            if (off == 32'h4000 + 32'(8 * h)) return m_cmp[h][31:0];
            if (off == 32'h4004 + 32'(8 * h)) return m_cmp[h][63:32];
        end
        return 32'd0;
    endfunction

    task automatic m_clock(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic [63:0] mt;
        if (!rst) begin
            m_reset();
            return;
        end
        off = a - BASE;
        mt  = m_mt();
        for (int h = 0; h < NH; h++) e_tirq[h] = (mt >= m_cmp[h]);
        e_sirq = m_msip;
        if (re && off == 32'hBFF8) m_shadow = mt[63:32];
        m_n++;
        if (we) begin
            if (off == 32'hBFF8) begin m_base = {mt[63:32], d}; m_n = 0; end
            if (off == 32'hBFFC) begin m_base = {d, mt[31:0]}; m_n = 0; m_shadow = d; end
            for (int h = 0; h < NH; h++) begin
                if (off == 32'(4 * h)) m_msip[h] = d[0];
                if (off == 32'h4000 + 32'(8 * h)) m_cmp[h][31:0]  = d;
                if (off == 32'h4004 + 32'(8 * h)) m_cmp[h][63:32] = d;
            end
        end
    endtask

    // One bus cycle: drive at negedge, check read data, clock, check irqs
    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        addr_i        = a;
        wdata_i       = d;
        write_valid_i = we;
        read_valid_i  = re;
        #1;
        if (re) check("read", {32'd0, rdata_o}, {32'd0, m_read(a)});
        @(posedge clk);
        m_clock(we, re, a, d);
        @(negedge clk);
        write_valid_i = 1'b0;
        read_valid_i  = 1'b0;
        check("timer_irq", {62'd0, timer_irq_o}, {62'd0, e_tirq});
        check("soft_irq", {62'd0, soft_irq_o}, {62'd0, e_sirq});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Read with an additional fixed expectation from the scenario
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        check(tag, {32'd0, rdata_o}, {32'd0, exp});
        step(1'b0, 1'b1, a, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;
        m_reset();
        addr_i        = 32'd0;
        wdata_i       = 32'd0;
        write_valid_i = 1'b0;
        read_valid_i  = 1'b0;
        rst           = 1'b0;
        @(negedge clk);

        // Reset
        idle(3);
        rst = 1'b1;
        rd_chk("rst_mtime_lo", A_MTLO, 32'd0);
        rd_chk("rst_mtime_hi", A_MTHI, 32'd0);
        rd_chk("rst_cmp0_lo", a_cmp(0, 0), 32'hFFFF_FFFF);
        rd_chk("rst_cmp0_hi", a_cmp(0, 1), 32'hFFFF_FFFF);

        // Prescaler: 40 cycles after release at PRESCALE=4
        idle(36);
        rd_chk("presc_40", A_MTLO, 32'd10);

        // Carry across the 32-bit boundary and full 64-bit wrap
        wr(A_MTLO, 32'hFFFF_FFFE);
        wr(A_MTHI, 32'h0000_0001);
        idle(2 * P);
        rd_chk("carry_lo", A_MTLO, 32'h0000_0000);
        rd_chk("carry_hi", A_MTHI, 32'h0000_0002);
        wr(A_MTLO, 32'hFFFF_FFFF);
        wr(A_MTHI, 32'hFFFF_FFFF);
        idle(P);
        rd_chk("wrap_lo", A_MTLO, 32'h0000_0000);
        rd_chk("wrap_hi", A_MTHI, 32'h0000_0000);

        // Timer interrupt on hart 1
        wr(A_MTHI, 32'd0);
        wr(A_MTLO, 32'd0);
        wr(a_cmp(1, 1), 32'd0);
        wr(a_cmp(1, 0), 32'd20);
        idle(100);
        check("tirq1_risen", {63'd0, timer_irq_o[1]}, 64'd1);
        check("tirq0_quiet", {63'd0, timer_irq_o[0]}, 64'd0);
        wr(a_cmp(1, 0), 32'hFFFF_FFFF);
        check("tirq1_hold", {63'd0, timer_irq_o[1]}, 64'd1);
        idle(1);
        check("tirq1_clear", {63'd0, timer_irq_o[1]}, 64'd0);

        // Software interrupt and unmapped accesses
        wr(a_msip(1), 32'hFFFF_FFFF);
        rd_chk("msip1", a_msip(1), 32'd1);
        check("sirq", {62'd0, soft_irq_o}, 64'd2);
        wr(a_msip(NH), 32'hFFFF_FFFF);
        rd_chk("msip_unmapped", a_msip(NH), 32'd0);
        rd_chk("msip0", a_msip(0), 32'd0);
        rd_chk("cmp_unmapped", a_cmp(NH, 0), 32'd0);
        rd_chk("misaligned", A_MTLO + 32'd1, 32'd0);
        rd_chk("below_base", BASE - 32'd4, 32'd0);

        // Reset in the middle of a prescaler period
        wr(A_MTHI, 32'd0);
        wr(A_MTLO, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(3);
        rd_chk("midrst_lo0", A_MTLO, 32'd0);
        rd_chk("midrst_lo1", A_MTLO, 32'd1);
        rd_chk("midrst_msip1", a_msip(1), 32'd0);
        rd_chk("midrst_cmp1", a_cmp(1, 0), 32'hFFFF_FFFF);

        // Tear-free read across a carry
        wr(A_MTLO, 32'hFFFF_FFFF);
        wr(A_MTHI, 32'h0000_0000);
        rd_chk("snap_lo", A_MTLO, 32'hFFFF_FFFF);
        idle(3);
`ifdef CLINT_SNAPSHOT_EN
        rd_chk("snap_hi", A_MTHI, 32'h0000_0000);
`else
        rd_chk("snap_hi", A_MTHI, 32'h0000_0001);
`endif

        // Random register traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       a = a_msip(0);
                1:       a = a_msip(1);
                2:       a = a_msip(NH);
                3:       a = a_cmp(0, 0);
                4:       a = a_cmp(0, 1);
                5:       a = a_cmp(1, 0);
                6:       a = a_cmp(1, 1);
                7:       a = A_MTLO;
                8:       a = A_MTHI;
                default: a = BASE + (32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFFC);
            endcase
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Parametrised core-local interruptor. Successor to the single-hart mtime/mtimecmp block.
- Provides one shared 64-bit mtime counter with a programmable prescaler, plus per-hart 64-bit mtimecmp and msip registers.
- Registered per-hart timer and software interrupt outputs.
- Sits on the 32-bit MMIO load/store path beside the LSU and drives interrupt-pending inputs of the CSR unit(s).

Parameters:
- NHART, 2, number of harts served (1..16).
- PRESCALE, 1, core clocks per mtime increment (>=1; 1 = every cycle).
- BASE_ADDR, 32'h0200_0000, byte base address of the register window.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset (reset when rst==0 at posedge clk)
- addr_i  input  32  byte address of access
- read_valid_i  input  1  read strobe, one cycle per access
- write_valid_i  input  1  write strobe, one cycle per access
- wdata_i  input  32  write data
- rdata_o  output  32  read data, combinational from addr_i
- timer_irq_o  output  NHART  per-hart machine timer interrupt
- soft_irq_o  output  NHART  per-hart machine software interrupt

Behaviour:
- Only clk is used as a clock. rst is synchronous and active-low; all state resets when rst==0 at a posedge.
- Address map (offsets from BASE_ADDR), word-aligned only:
  - msip[h] at 0x0000+4h
  - mtimecmp[h] low/high at 0x4000+8h / 0x4004+8h
  - mtime low/high at 0xBFF8 / 0xBFFC
  - h >= NHART, or any other offset, is unmapped.
- Reset values:
  - mtime = 0; prescaler count = 0.
  - every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - msip = 0.
  - timer_irq_o = 0; soft_irq_o = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick asserted in the cycle the count equals PRESCALE-1.
  - mtime <= mtime + 1 on tick, full 64-bit carry. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- mtime write:
  - Writing either half replaces that half; the other half holds.
  - No increment that cycle, even if tick. Prescaler count resets to 0.
- mtimecmp write: replaces the addressed half only. The counter is unaffected.
- msip write: only bit 0 is stored; bits 31:1 read as 0.
- Reads:
  - rdata_o returns the addressed register (msip zero-extended).
  - Unmapped addresses read 0. Writes to unmapped addresses are ignored, no error.
- read_valid_i has no side effect unless CLINT_SNAPSHOT_EN is defined.
- write_valid_i and read_valid_i asserted together: write takes effect, read returns the pre-write value.
- Interrupt outputs, registered with 1-cycle latency:
  - timer_irq_o[h] <= ({mtime_hi,mtime_lo} >= mtimecmp[h]), unsigned 64-bit compare on the current (pre-update) mtime.
  - soft_irq_o[h] <= msip[h].
  - After a write lowering mtimecmp below mtime, the irq rises on the 2nd posedge after the write. Raising mtimecmp above mtime clears it likewise.
- Reset asserted mid-count discards the prescaler state; counting restarts from 0 after rst returns high.

Optional Feature:
- Macro: CLINT_SNAPSHOT_EN.
- Defined:
  - A read (read_valid_i) of mtime low copies mtime high into a 32-bit shadow register in the same cycle.
  - A subsequent read of mtime high returns the shadow, not the live value, giving tear-free 64-bit reads across a carry.
  - Shadow resets to 0 and is also updated on any mtime high write.
- Not defined: no shadow; mtime high reads are live. Software must use the hi-lo-hi retry loop.

Test Plan:
- Reset: hold rst=0 3 cycles, release -> mtime reads 0/0, mtimecmp0 low/high read FFFF_FFFF, timer_irq_o=0, soft_irq_o=0.
- Prescaler: PRESCALE=4, run 40 cycles after reset -> mtime low reads 10; PRESCALE=1, 40 cycles -> reads 40.
- Carry: write mtime low=FFFF_FFFE, high=0000_0001, PRESCALE=1 -> after 2 ticks low=0000_0000, high=0000_0002.
- Timer irq: mtime=0, write mtimecmp1 high=0 then low=20 -> timer_irq_o[1] rises when mtime>=20 (one cycle late), timer_irq_o[0] stays 0; write mtimecmp1 low=FFFF_FFFF -> timer_irq_o[1] deasserts 2 posedges later.
- Software irq / unmapped: write 0xFFFF_FFFF to msip1 -> reads 1, soft_irq_o=2'b10; write to msip at h=NHART -> no state change, reads 0.
- Snapshot (CLINT_SNAPSHOT_EN): mtime=0000_0000_FFFF_FFFF, read low (returns FFFF_FFFF), wait 3 cycles, read high -> 0000_0000 with macro, 0000_0001 without.
